hazard3_ahbl_arbiter: RTL and testbench



---
 rtl/hazard3_ahbl_arbiter_if.sv | 47 ++++
 rtl/hazard3_ahbl_arbiter.sv | 113 +++++++++++
 tb/tb_hazard3_ahbl_arbiter.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard3_ahbl_arbiter_if.sv
// Bus bundle for hazard3_ahbl_arbiter: N core-side address/data channels plus one AHB-Lite master.
// The master modport is the arbiter's view; the slave modport is the surrounding system's view.
interface hazard3_ahbl_arbiter_if #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
);
    // Core-side channels
    logic [N_PORTS-1:0]          up_aph_req;
    logic [N_PORTS-1:0]          up_aph_panic;
    logic [N_PORTS-1:0]          up_aph_ready;
    logic [N_PORTS-1:0]          up_dph_ready;
    logic [N_PORTS-1:0]          up_dph_err;
    logic [N_PORTS*W_ADDR-1:0]   up_haddr;
    logic [N_PORTS*3-1:0]        up_hsize;
    logic [N_PORTS-1:0]          up_hwrite;
    logic [N_PORTS*4-1:0]        up_hprot;
    logic [N_PORTS*W_DATA-1:0]   up_wdata;
    logic [W_DATA-1:0]           up_rdata;

    // AHB-Lite master
    logic [W_ADDR-1:0]           haddr;
    logic                        hwrite;
    logic [1:0]                  htrans;
    logic [2:0]                  hsize;
    logic [2:0]                  hburst;
    logic [3:0]                  hprot;
    logic                        hmastlock;
    logic                        hready;
    logic                        hresp;
    logic [W_DATA-1:0]           hwdata;
    logic [W_DATA-1:0]           hrdata;

    modport master (
        input  up_aph_req, up_aph_panic, up_haddr, up_hsize, up_hwrite, up_hprot, up_wdata,
        output up_aph_ready, up_dph_ready, up_dph_err, up_rdata,
        output haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        input  hready, hresp, hrdata
    );

    modport slave (
        output up_aph_req, up_aph_panic, up_haddr, up_hsize, up_hwrite, up_hprot, up_wdata,
        input  up_aph_ready, up_dph_ready, up_dph_err, up_rdata,
        input  haddr, hwrite, htrans, hsize, hburst, hprot, hmastlock, hwdata,
        output hready, hresp, hrdata
    );
endinterface

// File: rtl/hazard3_ahbl_arbiter.sv
// N-requester AHB-Lite master port: panic-filtered arbitration, held grant across wait states,
// data-phase ownership tracking. Define HAZARD3_ARB_ROUND_ROBIN_EN for round-robin instead of fixed priority.
module hazard3_ahbl_arbiter #(
    parameter int N_PORTS = 2,
    parameter int W_ADDR  = 32,
    parameter int W_DATA  = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    hazard3_ahbl_arbiter_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;

    logic [N_PORTS-1:0] req_panic;
    logic [N_PORTS-1:0] eligible;
    logic [N_PORTS-1:0] grant_arb;
    logic [N_PORTS-1:0] grant;
    logic [N_PORTS-1:0] aph_hold_sel;
    logic [N_PORTS-1:0] dph_owner;
    logic               aph_hold;
    logic               aph_valid;
    logic               err_cancel;

    // Panicking requesters shut everyone else out while any of them is asking.
    assign req_panic  = bus.up_aph_req & bus.up_aph_panic;
    assign eligible   = (|req_panic) ? req_panic : bus.up_aph_req;
    assign err_cancel = bus.hresp & ~bus.hready;

`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
    localparam int RR_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    logic [RR_W-1:0]    rr_last;
    logic [RR_W-1:0]    grant_idx;
    logic [N_PORTS-1:0] above_last;
    logic [N_PORTS-1:0] elig_above;

    // First eligible index after rr_last, falling back to the lowest eligible index on wrap.
    // NOTE: every variable written in an always_comb gets a default first so no latch is inferred.
    always_comb begin
        above_last = '0;
        grant_idx  = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            above_last[i] = (i > int'(rr_last));
            if (grant[i]) grant_idx = RR_W'(i);
        end
        elig_above = eligible & above_last;
        if (|elig_above) grant_arb = elig_above & (~elig_above + N_PORTS'(1));
        else             grant_arb = eligible & (~eligible + N_PORTS'(1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_last <= RR_W'(N_PORTS - 1);
        end else if (bus.hready && aph_valid) begin
            rr_last <= grant_idx;
        end
    end
`else
    // Isolate the lowest set bit: index 0 is the highest priority.
    assign grant_arb = eligible & (~eligible + N_PORTS'(1));
`endif

    // Reset and the first error cycle force IDLE; a stalled address phase keeps its owner.
    assign grant     = (rst || err_cancel) ? '0 : (aph_hold ? aph_hold_sel : grant_arb);
    assign aph_valid = |grant;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aph_hold     <= 1'b0;
            aph_hold_sel <= '0;
            dph_owner    <= '0;
        end else begin
            if (err_cancel) begin
                aph_hold <= 1'b0;
            end else if (aph_valid && !bus.hready) begin
                aph_hold     <= 1'b1;
                aph_hold_sel <= grant;
            end else if (bus.hready) begin
                aph_hold <= 1'b0;
            end
            if (bus.hready) dph_owner <= grant;
        end
    end

    always_comb begin
        bus.haddr  = '0;
        bus.hsize  = '0;
        bus.hwrite = 1'b0;
        bus.hprot  = '0;
        bus.hwdata = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (grant[i]) begin
                bus.haddr  = bus.haddr  | bus.up_haddr[i*W_ADDR +: W_ADDR];
                bus.hsize  = bus.hsize  | bus.up_hsize[i*3 +: 3];
                bus.hwrite = bus.hwrite | bus.up_hwrite[i];
                bus.hprot  = bus.hprot  | bus.up_hprot[i*4 +: 4];
            end
            if (dph_owner[i]) bus.hwdata = bus.hwdata | bus.up_wdata[i*W_DATA +: W_DATA];
        end
    end

    assign bus.htrans       = aph_valid ? HTRANS_NSEQ : HTRANS_IDLE;
    assign bus.hburst       = 3'b000;
    assign bus.hmastlock    = 1'b0;
    assign bus.up_aph_ready = bus.hready ? grant : '0;
    assign bus.up_dph_ready = bus.hready ? dph_owner : '0;
    assign bus.up_dph_err   = bus.hresp ? dph_owner : '0;
    assign bus.up_rdata     = bus.hrdata;

endmodule

// File: tb/tb_hazard3_ahbl_arbiter.sv
// Self-checking bench for hazard3_ahbl_arbiter: a per-cycle index-based model plus directed literal checks.
// Builds with N_PORTS=3 and a round-robin sequence when HAZARD3_ARB_ROUND_ROBIN_EN is defined.
module tb_hazard3_ahbl_arbiter;

`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
    localparam int N = 3;
`else
    localparam int N = 2;
`endif
    localparam int AW = 32;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [N-1:0]  req, panic, wr;
    logic [AW-1:0] addr  [N];
    logic [DW-1:0] wdata [N];
    logic [2:0]    size  [N];
    logic [3:0]    prot  [N];

    hazard3_ahbl_arbiter_if #(.N_PORTS(N), .W_ADDR(AW), .W_DATA(DW)) bus ();

    hazard3_ahbl_arbiter #(.N_PORTS(N), .W_ADDR(AW), .W_DATA(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.up_aph_req   = req;
        bus.up_aph_panic = panic;
        bus.up_hwrite    = wr;
        bus.up_haddr     = '0;
        bus.up_wdata     = '0;
        bus.up_hsize     = '0;
        bus.up_hprot     = '0;
        for (int i = 0; i < N; i++) begin
            bus.up_haddr[i*AW +: AW] = addr[i];
            bus.up_wdata[i*DW +: DW] = wdata[i];
            bus.up_hsize[i*3 +: 3]   = size[i];
            bus.up_hprot[i*4 +: 4]   = prot[i];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] onehot(input int idx);
        return (idx < 0) ? 64'd0 : (64'd1 << idx);
    endfunction

    // Model: which requester wins, given the eligible set and the last winner.
    function automatic int pick(input logic [N-1:0] el, input int last);
`ifdef HAZARD3_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (last + k) % N;
            if (el[i]) return i;
        end
`else
        for (int i = 0; i < N; i++) if (el[i]) return i;
`endif
        return -1;
    endfunction

    // Model state as plain indices; -1 means nobody.
    int m_hold  = -1;
    int m_owner = -1;
    int m_last  = N - 1;

    always @(negedge clk) begin : compare
        logic [N-1:0] rp, el;
        logic         err;
        int           g;
        if (rst) begin
            m_hold  = -1;
            m_owner = -1;
            m_last  = N - 1;
        end
        rp  = req & panic;
        el  = (rp != '0) ? rp : req;
        err = bus.hresp && !bus.hready;
        if (rst || err)      g = -1;
        else if (m_hold >= 0) g = m_hold;
        else                 g = pick(el, m_last);

        check("cmp_htrans",    bus.htrans,       (g >= 0) ? 64'd2 : 64'd0);
        check("cmp_haddr",     bus.haddr,        (g >= 0) ? 64'(addr[g]) : 64'd0);
        check("cmp_hsize",     bus.hsize,        (g >= 0) ? 64'(size[g]) : 64'd0);
        check("cmp_hwrite",    bus.hwrite,       (g >= 0) ? 64'(wr[g]) : 64'd0);
        check("cmp_hprot",     bus.hprot,        (g >= 0) ? 64'(prot[g]) : 64'd0);
        check("cmp_aph_ready", bus.up_aph_ready, bus.hready ? onehot(g) : 64'd0);
        check("cmp_dph_ready", bus.up_dph_ready, bus.hready ? onehot(m_owner) : 64'd0);
        check("cmp_dph_err",   bus.up_dph_err,   bus.hresp ? onehot(m_owner) : 64'd0);
        check("cmp_hwdata",    bus.hwdata,       (m_owner >= 0) ? 64'(wdata[m_owner]) : 64'd0);
        check("cmp_rdata",     bus.up_rdata,     64'(bus.hrdata));
        check("cmp_tied",      {bus.hburst, bus.hmastlock}, 64'd0);

        if (!rst) begin
            if (err)                         m_hold = -1;
            else if (g >= 0 && !bus.hready)  m_hold = g;
            else if (bus.hready)             m_hold = -1;
            if (bus.hready) begin
                m_owner = g;
                if (g >= 0) m_last = g;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        req = '0; panic = '0; wr = '0;
        for (int i = 0; i < N; i++) begin
            addr[i] = '0; wdata[i] = '0; size[i] = '0; prot[i] = '0;
        end
        bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = '0;

        tick(); tick();
        #2;
        check("reset_htrans",    bus.htrans, 0);
        check("reset_dph_ready", bus.up_dph_ready, 0);
        check("reset_hwdata",    bus.hwdata, 0);
        tick();
        rst = 1'b0;

`ifndef HAZARD3_ARB_ROUND_ROBIN_EN
        // Single requester read
        req = 2'b10; addr[1] = 32'h2000_0004; size[1] = 3'd2; prot[1] = 4'h3;
        #2;
        check("t1_htrans", bus.htrans, 2);
        check("t1_haddr",  bus.haddr, 32'h2000_0004);
        check("t1_hsize",  bus.hsize, 2);
        check("t1_aph",    bus.up_aph_ready, 2'b10);
        tick(); req = 2'b00; bus.hrdata = 32'hCAFE_0001;
        #2;
        check("t1_dph",    bus.up_dph_ready, 2'b10);
        check("t1_rdata",  bus.up_rdata, 32'hCAFE_0001);
        check("t1_idle",   bus.htrans, 0);
        tick();

        // Simultaneous writes, fixed priority, pipelined data
        req = 2'b11; wr = 2'b11; addr[0] = 32'h0000_1000; addr[1] = 32'h0000_1004;
        wdata[0] = 32'hA5A5_0000; wdata[1] = 32'h5A5A_1111;
        #2;
        check("t2_aph0",   bus.up_aph_ready, 2'b01);
        check("t2_haddr0", bus.haddr, 32'h0000_1000);
        tick(); req = 2'b10;
        #2;
        check("t2_aph1",   bus.up_aph_ready, 2'b10);
        check("t2_haddr1", bus.haddr, 32'h0000_1004);
        check("t2_wdata0", bus.hwdata, 32'hA5A5_0000);
        tick(); req = 2'b00;
        #2;
        check("t2_wdata1", bus.hwdata, 32'h5A5A_1111);
        check("t2_dph1",   bus.up_dph_ready, 2'b10);
        tick(); wr = 2'b00;

        // Wait states hold port1's address despite a panicking port0
        req = 2'b10; addr[1] = 32'h3000_0010; bus.hready = 1'b0;
        #2;
        check("t3_haddr_a", bus.haddr, 32'h3000_0010);
        check("t3_aph_a",   bus.up_aph_ready, 0);
        tick(); req = 2'b11; panic = 2'b01; addr[0] = 32'h4000_0000;
        #2;
        check("t3_haddr_b", bus.haddr, 32'h3000_0010);
        check("t3_aph_b",   bus.up_aph_ready, 0);
        tick();
        #2;
        check("t3_haddr_c", bus.haddr, 32'h3000_0010);
        tick(); bus.hready = 1'b1;
        #2;
        check("t3_aph_d",   bus.up_aph_ready, 2'b10);
        tick(); req = 2'b01;
        #2;
        check("t3_aph_e",   bus.up_aph_ready, 2'b01);
        check("t3_haddr_e", bus.haddr, 32'h4000_0000);
        check("t3_dph_e",   bus.up_dph_ready, 2'b10);
        tick(); req = 2'b00; panic = 2'b00;
        tick();

        // Two-cycle error on port0's write data phase, port1 pending
        req = 2'b01; wr = 2'b01; addr[0] = 32'h5000_0000; wdata[0] = 32'hDEAD_BEEF;
        #2;
        check("t4_aph0",  bus.up_aph_ready, 2'b01);
        tick(); req = 2'b10; wr = 2'b00; addr[1] = 32'h5000_0004;
        bus.hresp = 1'b1; bus.hready = 1'b0;
        #2;
        check("t4_err_a",    bus.up_dph_err, 2'b01);
        check("t4_idle_a",   bus.htrans, 0);
        check("t4_wdata_a",  bus.hwdata, 32'hDEAD_BEEF);
        tick(); bus.hready = 1'b1;
        #2;
        check("t4_err_b",    bus.up_dph_err, 2'b01);
        check("t4_dph_b",    bus.up_dph_ready, 2'b01);
        check("t4_haddr_b",  bus.haddr, 32'h5000_0004);
        check("t4_aph_b",    bus.up_aph_ready, 2'b10);
        tick(); req = 2'b00; bus.hresp = 1'b0;
        #2;
        check("t4_dph_c",    bus.up_dph_ready, 2'b10);
        check("t4_err_c",    bus.up_dph_err, 0);
        tick();

        // Panic overrides fixed priority
        req = 2'b11; panic = 2'b10; addr[0] = 32'h6000_0000; addr[1] = 32'h6000_0004;
        #2;
        check("t5_aph_p",   bus.up_aph_ready, 2'b10);
        check("t5_haddr_p", bus.haddr, 32'h6000_0004);
        tick(); req = 2'b01; panic = 2'b00;
        #2;
        check("t5_aph_n",   bus.up_aph_ready, 2'b01);
        tick(); req = 2'b00;
`else
        // Round-robin over three continuous requesters, then reset mid-sequence
        for (int i = 0; i < N; i++) addr[i] = 32'h100 * (i + 1);
        req = 3'b111;
        #2; check("rr_g0", bus.up_aph_ready, 3'b001);
        tick(); #2; check("rr_g1", bus.up_aph_ready, 3'b010);
        tick(); #2; check("rr_g2", bus.up_aph_ready, 3'b100);
        tick(); #2; check("rr_g3", bus.up_aph_ready, 3'b001);
        check("rr_haddr3", bus.haddr, 32'h100);
        tick(); rst = 1'b1;
        #2;
        check("rr_rst_htrans", bus.htrans, 0);
        check("rr_rst_aph",    bus.up_aph_ready, 0);
        check("rr_rst_dph",    bus.up_dph_ready, 0);
        check("rr_rst_haddr",  bus.haddr, 0);
        tick(); rst = 1'b0;
        #2;
        check("rr_after_rst", bus.up_aph_ready, 3'b001);
        tick(); req = '0;
`endif
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
